// File: rtl/pronet_cfg_sequencer.sv
// AXI-lite master that replays proNet weights and biases from a synchronous-read config memory.
// Sequence: soft-reset clear, weight pass (layer/neuron/weights), bias pass, done pulse.
module pronet_cfg_sequencer #(
  parameter int unsigned NUM_LAYERS         = 4,
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned MEM_AW             = 16,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [NUM_LAYERS*8-1:0]       layer_neurons,
  input  logic [NUM_LAYERS*10-1:0]      layer_inputs,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_error,
  output logic                          mem_rd_en,
  output logic [MEM_AW-1:0]             mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready
);

  localparam int unsigned LW = $clog2(NUM_LAYERS + 2);

  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] AddrWeight  = C_S_AXI_ADDR_WIDTH'(0);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] AddrBias    = C_S_AXI_ADDR_WIDTH'(4);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] AddrLayer   = C_S_AXI_ADDR_WIDTH'(12);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] AddrNeuron  = C_S_AXI_ADDR_WIDTH'(16);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] AddrSoftRst = C_S_AXI_ADDR_WIDTH'(28);

  typedef enum logic [3:0] {
    StIdle, StClr,
    StWLayer, StWNeuron, StWFetch, StWWait, StWWrite,
    StBLayer, StBNeuron, StBFetch, StBWait, StBWrite,
    StDone
  } state_e;

  typedef enum logic [1:0] {WrIdle, WrIssue, WrResp} wr_e;

  state_e                          r_state;
  wr_e                             r_wr_phase;
  logic [LW-1:0]                   r_layer;
  logic [7:0]                      r_neuron;
  logic [9:0]                      r_input;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_cfg_error;
  logic                            r_mem_rd_en;
  logic [MEM_AW-1:0]               r_mem_addr;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic                            r_awvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic                            r_wvalid;
  logic                            r_bready;

  logic [7:0]                      w_cur_n;
  logic [9:0]                      w_cur_m;
  logic                            w_layer_valid;
  logic                            w_last_neuron;
  logic                            w_last_input;
  logic                            w_wr_req;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   w_wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_wr_data;
  logic                            w_wr_done;
  logic                            w_aw_ok;
  logic                            w_w_ok;

  always_comb begin
    w_cur_n = '0;
    w_cur_m = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (r_layer == LW'(k + 1)) begin
        w_cur_n = layer_neurons[k*8 +: 8];
        w_cur_m = layer_inputs[k*10 +: 10];
      end
    end
  end

  assign w_layer_valid = (r_layer <= LW'(NUM_LAYERS));
  assign w_last_neuron = (({1'b0, r_neuron} + 9'd1) >= {1'b0, w_cur_n});
  assign w_last_input  = (({1'b0, r_input} + 11'd1) >= {1'b0, w_cur_m});
  assign w_wr_done     = (r_wr_phase == WrResp) && m_axi_bvalid;
  assign w_aw_ok       = !r_awvalid || m_axi_awready;
  assign w_w_ok        = !r_wvalid || m_axi_wready;

  // Write request for the current main state; memory data is only valid in the launch cycle.
  always_comb begin
    w_wr_req  = 1'b0;
    w_wr_addr = AddrSoftRst;
    w_wr_data = '0;
    unique case (r_state)
      StClr: w_wr_req = 1'b1;
      StWLayer, StBLayer: begin
        w_wr_req  = w_layer_valid && (w_cur_n != 8'd0);
        w_wr_addr = AddrLayer;
        w_wr_data = C_S_AXI_DATA_WIDTH'(r_layer);
      end
      StWNeuron, StBNeuron: begin
        w_wr_req  = 1'b1;
        w_wr_addr = AddrNeuron;
        w_wr_data = C_S_AXI_DATA_WIDTH'(r_neuron);
      end
      StWWrite, StBWrite: begin
        w_wr_req  = 1'b1;
        w_wr_addr = (r_state == StWWrite) ? AddrWeight : AddrBias;
        w_wr_data = C_S_AXI_DATA_WIDTH'(mem_rd_data);
      end
      default: w_wr_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_wr_phase  <= WrIdle;
      r_layer     <= '0;
      r_neuron    <= '0;
      r_input     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_error <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_mem_rd_en <= 1'b0;

      unique case (r_wr_phase)
        WrIdle: begin
          if (w_wr_req) begin
            r_awaddr   <= w_wr_addr;
            r_wdata    <= w_wr_data;
            r_awvalid  <= 1'b1;
            r_wvalid   <= 1'b1;
            r_wr_phase <= WrIssue;
          end
        end
        WrIssue: begin
          if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_bready   <= 1'b1;
            r_wr_phase <= WrResp;
          end
        end
        WrResp: begin
          if (m_axi_bvalid) begin
            r_bready   <= 1'b0;
            r_wr_phase <= WrIdle;
            if (m_axi_bresp != 2'b00) r_cfg_error <= 1'b1;
          end
        end
        default: r_wr_phase <= WrIdle;
      endcase

      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_busy      <= 1'b1;
            r_cfg_error <= 1'b0;
            r_mem_addr  <= '0;
            r_state     <= StClr;
          end
        end
        StClr: begin
          if (w_wr_done) begin
            r_layer <= LW'(1);
            r_state <= StWLayer;
          end
        end
        StWLayer, StBLayer: begin
          if (!w_layer_valid) begin
            r_layer <= LW'(1);
            if (r_state == StWLayer) begin
              r_state <= StBLayer;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end else if (w_cur_n == 8'd0) begin
            r_layer <= r_layer + LW'(1);
          end else if (w_wr_done) begin
            r_neuron <= '0;
            r_state  <= (r_state == StWLayer) ? StWNeuron : StBNeuron;
          end
        end
        StWNeuron: begin
          if (w_wr_done) begin
            r_input <= '0;
            if (w_cur_m != 10'd0) begin
              r_state <= StWFetch;
            end else if (w_last_neuron) begin
              r_layer <= r_layer + LW'(1);
              r_state <= StWLayer;
            end else begin
              r_neuron <= r_neuron + 8'd1;
            end
          end
        end
        StBNeuron: begin
          if (w_wr_done) r_state <= StBFetch;
        end
        StWFetch, StBFetch: begin
          r_mem_rd_en <= 1'b1;
          r_state     <= (r_state == StWFetch) ? StWWait : StBWait;
        end
        // The RAM has already captured the address, so advance it while data returns.
        StWWait, StBWait: begin
          r_mem_addr <= r_mem_addr + MEM_AW'(1);
          r_state    <= (r_state == StWWait) ? StWWrite : StBWrite;
        end
        StWWrite: begin
          if (w_wr_done) begin
            if (!w_last_input) begin
              r_input <= r_input + 10'd1;
              r_state <= StWFetch;
            end else if (w_last_neuron) begin
              r_layer <= r_layer + LW'(1);
              r_state <= StWLayer;
            end else begin
              r_neuron <= r_neuron + 8'd1;
              r_state  <= StWNeuron;
            end
          end
        end
        StBWrite: begin
          if (w_wr_done) begin
            if (w_last_neuron) begin
              r_layer <= r_layer + LW'(1);
              r_state <= StBLayer;
            end else begin
              r_neuron <= r_neuron + 8'd1;
              r_state  <= StBNeuron;
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign cfg_error     = r_cfg_error;
  assign mem_rd_en     = r_mem_rd_en;
  assign mem_addr      = r_mem_addr;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;

endmodule

// File: tb/tb_pronet_cfg_sequencer.sv
// Bench for pronet_cfg_sequencer: AXI-lite slave and config RAM models with a write scoreboard.
module tb_pronet_cfg_sequencer;

  localparam int NL = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] layer_neurons = '0;
  logic [19:0] layer_inputs = '0;
  logic        busy, done, cfg_error, mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rd_data = '0;
  logic [4:0]  awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;

  pronet_cfg_sequencer #(
    .NUM_LAYERS(NL), .DATA_WIDTH(16), .MEM_AW(16),
    .C_S_AXI_ADDR_WIDTH(5), .C_S_AXI_DATA_WIDTH(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .layer_neurons(layer_neurons), .layer_inputs(layer_inputs),
    .busy(busy), .done(done), .cfg_error(cfg_error),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  mem [64];
  int  n_checks = 0;
  int  n_pass = 0;
  int  exp_rd;

  // Slave/monitor state
  int  aw_delay = 0, w_delay = 0, err_at = 0;
  int  wr_cnt, done_cnt, rd_cnt, rd_lo, rd_hi;
  int  aw_cnt, w_cnt, cap_addr, cap_data, aw_prev_addr, w_prev_data;
  bit  got_aw, got_w, aw_prev, w_prev, br_prev;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_cfg(input int n1, input int m1, input int n2, input int m2);
    int ns[2];
    int ms[2];
    int a;
    wr_t e;
    ns[0] = n1; ns[1] = n2; ms[0] = m1; ms[1] = m2;
    layer_neurons = {8'(n2), 8'(n1)};
    layer_inputs  = {10'(m2), 10'(m1)};
    exp_q.delete();
    a = 0;
    e.addr = 28; e.data = 0; exp_q.push_back(e);
    for (int k = 0; k < 2; k++) begin
      if (ns[k] == 0) continue;
      e.addr = 12; e.data = k + 1; exp_q.push_back(e);
      for (int j = 0; j < ns[k]; j++) begin
        e.addr = 16; e.data = j; exp_q.push_back(e);
        for (int i = 0; i < ms[k]; i++) begin
          e.addr = 0; e.data = mem[a]; exp_q.push_back(e);
          a++;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (ns[k] == 0) continue;
      e.addr = 12; e.data = k + 1; exp_q.push_back(e);
      for (int j = 0; j < ns[k]; j++) begin
        e.addr = 16; e.data = j; exp_q.push_back(e);
        e.addr = 4; e.data = mem[a]; exp_q.push_back(e);
        a++;
      end
    end
    exp_rd = a;
  endtask

  // AXI-lite slave + sync-read memory, all decisions taken on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        got_aw = 1'b0; got_w = 1'b0; aw_cnt = 0; w_cnt = 0;
        aw_prev = 1'b0; w_prev = 1'b0; br_prev = 1'b0;
        continue;
      end
      if (done) done_cnt++;
      if (mem_rd_en) begin
        mem_rd_data = 16'(mem[mem_addr[5:0]]);
        rd_cnt++;
        if (int'(mem_addr) < rd_lo) rd_lo = int'(mem_addr);
        if (int'(mem_addr) > rd_hi) rd_hi = int'(mem_addr);
      end
      if (awready && aw_prev) begin
        got_aw = 1'b1; cap_addr = aw_prev_addr; awready = 1'b0; aw_cnt = 0;
        check("awvalid_drop", awvalid, 0);
      end else if (awvalid && !got_aw) begin
        if (aw_cnt >= aw_delay) awready = 1'b1;
        else aw_cnt++;
      end
      if (wready && w_prev) begin
        got_w = 1'b1; cap_data = w_prev_data; wready = 1'b0; w_cnt = 0;
        check("wvalid_drop", wvalid, 0);
      end else if (wvalid && !got_w) begin
        if (w_cnt >= w_delay) wready = 1'b1;
        else w_cnt++;
      end
      if (bvalid && br_prev) begin
        bvalid = 1'b0; bresp = 2'b00;
      end
      if (got_aw && got_w) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check($sformatf("wr%0d_extra", wr_cnt), 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check($sformatf("wr%0d_addr", wr_cnt), cap_addr, e.addr);
          check($sformatf("wr%0d_data", wr_cnt), cap_data, e.data);
        end
        bvalid = 1'b1;
        bresp  = (wr_cnt == err_at) ? 2'b10 : 2'b00;
        got_aw = 1'b0; got_w = 1'b0;
      end
      aw_prev = awvalid; aw_prev_addr = int'(awaddr);
      w_prev = wvalid;   w_prev_data = int'(wdata);
      br_prev = bready;
    end
  end

  task automatic clear_stats();
    wr_cnt = 0; done_cnt = 0; rd_cnt = 0; rd_lo = 9999; rd_hi = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic run_cfg(input string name, input int exp_writes, input int exp_err,
                         input int restart_at);
    bit poked;
    poked = 1'b0;
    clear_stats();
    pulse_start();
    check({name, "_busy"}, busy, 1);
    check({name, "_errclr"}, cfg_error, 0);
    for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
      @(negedge clk); #1;
      if (start) start = 1'b0;
      if (restart_at > 0 && !poked && wr_cnt >= restart_at) begin
        start = 1'b1; poked = 1'b1;
      end
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check({name, "_done_once"}, done_cnt, 1);
    check({name, "_writes"}, wr_cnt, exp_writes);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_reads"}, rd_cnt, exp_rd);
    check({name, "_rd_lo"}, rd_lo, 0);
    check({name, "_rd_hi"}, rd_hi, exp_rd - 1);
    check({name, "_idle"}, busy, 0);
    check({name, "_cfg_error"}, cfg_error, exp_err);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {busy, done, cfg_error, mem_rd_en, awvalid, wvalid, bready}, 0);
    check({name, "_mem_addr"}, mem_addr, 0);
    check({name, "_awaddr"}, awaddr, 0);
    check({name, "_wdata"}, wdata, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = i;
    clear_stats();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    set_cfg(2, 3, 1, 2);
    run_cfg("base", 22, 0, 0);

    aw_delay = 3; w_delay = 1;
    set_cfg(2, 3, 1, 2);
    run_cfg("slow", 22, 0, 0);
    aw_delay = 0; w_delay = 0;

    set_cfg(2, 3, 0, 2);
    run_cfg("skip_l2", 15, 0, 0);

    err_at = 5;
    set_cfg(2, 3, 1, 2);
    run_cfg("bresp_err", 22, 1, 0);
    err_at = 0;
    set_cfg(2, 3, 1, 2);
    run_cfg("after_err", 22, 0, 0);

    set_cfg(2, 3, 1, 2);
    run_cfg("restart_ign", 22, 0, 10);

    // Reset in the middle of the weight pass, then a clean restart.
    set_cfg(2, 3, 1, 2);
    clear_stats();
    pulse_start();
    for (int c = 0; c < 2000 && wr_cnt < 10; c++) @(negedge clk);
    #1;
    check("midrst_reached", wr_cnt, 10);
    reset_n = 1'b0;
    @(negedge clk); #1;
    check_all_zero("midrst");
    @(negedge clk); #1;
    reset_n = 1'b1;
    set_cfg(2, 3, 1, 2);
    run_cfg("post_rst", 22, 0, 0);

    set_cfg(2, 0, 1, 2);
    run_cfg("m_zero", 16, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
